weight_load_ctrl: RTL and testbench

Sequencer that moves weight tiles from the weight memory into the 2x2 systolic array.
- On `start` it walks `num_tiles` consecutive 4-entry tiles beginning at `base_addr`.
- The weight memory reads combinationally; the block latches each 4-weight read, then shifts it into the array as two column-pair pushes, bottom row first.
- Sits between the top-level controller (start/done) and the weight memory / array weight-shift inputs.
- Stalls on the array's `array_ready` handshake.

---
 rtl/weight_load_ctrl_pkg.sv | 18 +
 rtl/weight_load_ctrl_if.sv | 25 ++
 rtl/weight_load_ctrl.sv | 118 +++++++++++
 tb/tb_weight_load_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/weight_load_ctrl_pkg.sv
// Shared types and constants for the TPU weight-load path.
package tpu_pkg;

  localparam int ARRAY_DIM   = 2;
  localparam int TILE_STRIDE = 4;
  localparam int WL_ADDR_W   = 13;
  localparam int WL_DATA_W   = 8;
  localparam int WL_CNT_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_DONE     = 3'd4
  } wl_state_t;

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Weight-memory read port plus systolic-array weight-shift port.
interface weight_load_ctrl_if #(
  parameter int ADDR_W = tpu_pkg::WL_ADDR_W,
  parameter int DATA_W = tpu_pkg::WL_DATA_W
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_w0;
  logic [DATA_W-1:0] mem_w1;
  logic [DATA_W-1:0] mem_w2;
  logic [DATA_W-1:0] mem_w3;
  logic              array_ready;
  logic [DATA_W-1:0] w_col0;
  logic [DATA_W-1:0] w_col1;
  logic              w_shift;

  modport master (
    output mem_addr, w_col0, w_col1, w_shift,
    input  mem_w0, mem_w1, mem_w2, mem_w3, array_ready
  );

  modport slave (
    input  mem_addr, w_col0, w_col1, w_shift,
    output mem_w0, mem_w1, mem_w2, mem_w3, array_ready
  );
endinterface

// File: rtl/weight_load_ctrl.sv
// Walks num_tiles 4-weight tiles from weight memory and pushes each into the
// 2x2 array as two column-pair shifts (bottom row first).
module weight_load_ctrl #(
  parameter int ADDR_W      = tpu_pkg::WL_ADDR_W,
  parameter int DATA_W      = tpu_pkg::WL_DATA_W,
  parameter int TILE_STRIDE = tpu_pkg::TILE_STRIDE,
  parameter int CNT_W       = tpu_pkg::WL_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    num_tiles,
  weight_load_ctrl_if.master  bus,
  output logic                tile_loaded,
  output logic                busy,
  output logic                done
);
  import tpu_pkg::*;

  localparam int NUM_W = ARRAY_DIM * ARRAY_DIM;

  wl_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  tiles_q, tiles_d;
  logic [DATA_W-1:0] w_q [NUM_W];
  logic [DATA_W-1:0] w_d [NUM_W];

  // Next-state, address/count update and tile latch
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tiles_d = tiles_q;
    w_d     = w_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          tiles_d = num_tiles;
          state_d = (num_tiles == {CNT_W{1'b0}}) ? ST_DONE : ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        w_d[0]  = bus.mem_w0;
        w_d[1]  = bus.mem_w1;
        w_d[2]  = bus.mem_w2;
        w_d[3]  = bus.mem_w3;
        state_d = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (bus.array_ready) begin
          state_d = ST_SHIFT_HI;
        end else begin
          state_d = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_HI: begin
        if (bus.array_ready) begin
          tiles_d = tiles_q - {{(CNT_W-1){1'b0}}, 1'b1};
          addr_d  = addr_q + ADDR_W'(TILE_STRIDE);
          state_d = (tiles_q > {{(CNT_W-1){1'b0}}, 1'b1}) ? ST_FETCH : ST_DONE;
        end else begin
          state_d = ST_SHIFT_HI;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, address, count and weight latch registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      tiles_q <= {CNT_W{1'b0}};
      for (int i = 0; i < NUM_W; i++) begin
        w_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tiles_q <= tiles_d;
      for (int i = 0; i < NUM_W; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  // Output decode; shift strobes follow array_ready so a stall holds the columns
  always_comb begin
    bus.mem_addr = addr_q;
    bus.w_col0   = {DATA_W{1'b0}};
    bus.w_col1   = {DATA_W{1'b0}};
    bus.w_shift  = 1'b0;
    tile_loaded  = 1'b0;
    done         = 1'b0;
    busy         = (state_q != ST_IDLE);
    case (state_q)
      ST_SHIFT_LO: begin
        bus.w_col0  = w_q[2];
        bus.w_col1  = w_q[3];
        bus.w_shift = bus.array_ready;
      end
      ST_SHIFT_HI: begin
        bus.w_col0  = w_q[0];
        bus.w_col1  = w_q[1];
        bus.w_shift = bus.array_ready;
        tile_loaded = bus.array_ready;
      end
      ST_DONE: done = 1'b1;
      default: done = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl: stimulus queues expected shift/done
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_weight_load_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] base_addr;
  logic [3:0]  num_tiles;
  logic        tile_loaded, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] mem [0:8191];

  typedef struct {
    int         kind;   // 0 = shift, 1 = done
    int         cyc;
    logic [7:0] c0;
    logic [7:0] c1;
    logic       tl;
  } ev_t;

  ev_t q[$];
  ev_t e;

  weight_load_ctrl_if #(.ADDR_W(13), .DATA_W(8)) bus ();

  weight_load_ctrl #(.ADDR_W(13), .DATA_W(8), .TILE_STRIDE(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_tiles(num_tiles), .bus(bus), .tile_loaded(tile_loaded),
    .busy(busy), .done(done)
  );

  assign bus.mem_w0 = mem[bus.mem_addr];
  assign bus.mem_w1 = mem[bus.mem_addr + 13'd1];
  assign bus.mem_w2 = mem[bus.mem_addr + 13'd2];
  assign bus.mem_w3 = mem[bus.mem_addr + 13'd3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_shift(input int c, input logic [7:0] a, input logic [7:0] b, input logic tl);
    ev_t n;
    n.kind = 0; n.cyc = c; n.c0 = a; n.c1 = b; n.tl = tl;
    q.push_back(n);
  endtask

  task automatic push_done(input int c);
    ev_t n;
    n.kind = 1; n.cyc = c; n.c0 = 8'd0; n.c1 = 8'd0; n.tl = 1'b0;
    q.push_back(n);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!busy && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout busy=%0b pending=%0d expected idle with 0 pending", nm, busy, q.size());
    end
  endtask

  task automatic issue(input logic [12:0] b, input logic [3:0] n);
    base_addr = b;
    num_tiles = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Monitor: every shift/tile_loaded/done presentation must match the queue head
  always @(negedge clk) begin
    if (!reset && (bus.w_shift || tile_loaded || done)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d shift=%0b tl=%0b done=%0b cols=%0d,%0d expected no event",
                 cyc, bus.w_shift, tile_loaded, done, bus.w_col0, bus.w_col1);
      end else begin
        e = q.pop_front();
        if (e.kind == 0) begin
          if (!(bus.w_shift && !done && bus.w_col0 == e.c0 && bus.w_col1 == e.c1 &&
                tile_loaded == e.tl && cyc == e.cyc)) begin
            errors++;
            $display("FAIL shift_event got cyc=%0d shift=%0b cols=%0d,%0d tl=%0b done=%0b expected cyc=%0d cols=%0d,%0d tl=%0b",
                     cyc, bus.w_shift, bus.w_col0, bus.w_col1, tile_loaded, done, e.cyc, e.c0, e.c1, e.tl);
          end
        end else begin
          if (!(done && !bus.w_shift && !tile_loaded && cyc == e.cyc)) begin
            errors++;
            $display("FAIL done_event got cyc=%0d done=%0b shift=%0b tl=%0b expected cyc=%0d done=1",
                     cyc, done, bus.w_shift, tile_loaded, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int s;
    for (int i = 0; i < 8192; i++) mem[i] = 8'd0;
    mem[13'h000F] = 8'd3;  mem[13'h0010] = 8'd5;  mem[13'h0011] = 8'd4;  mem[13'h0012] = 8'd6;
    mem[13'h0013] = 8'd7;  mem[13'h0014] = 8'd9;  mem[13'h0015] = 8'd8;  mem[13'h0016] = 8'd10;
    mem[13'h1FFE] = 8'h11; mem[13'h1FFF] = 8'h22; mem[13'h0000] = 8'h33; mem[13'h0001] = 8'h44;
    mem[13'h0002] = 8'h55; mem[13'h0003] = 8'h66; mem[13'h0004] = 8'h77; mem[13'h0005] = 8'h88;

    reset = 1'b1; start = 1'b0; base_addr = 13'd0; num_tiles = 4'd0; bus.array_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_shift", {31'd0, bus.w_shift}, 32'd0);
    chk("reset_tl", {31'd0, tile_loaded}, 32'd0);
    chk("reset_addr", {19'd0, bus.mem_addr}, 32'd0);
    chk("reset_cols", {16'd0, bus.w_col0, bus.w_col1}, 32'd0);

    // One tile, no stall
    s = cyc;
    push_shift(s + 2, 8'd4, 8'd6, 1'b0);
    push_shift(s + 3, 8'd3, 8'd5, 1'b1);
    push_done(s + 4);
    issue(13'h000F, 4'd1);
    chk("t1_fetch_addr", {19'd0, bus.mem_addr}, 32'h0F);
    chk("t1_busy_c1", {31'd0, busy}, 32'd1);
    tick(); chk("t1_busy_c2", {31'd0, busy}, 32'd1);
    tick(); chk("t1_busy_c3", {31'd0, busy}, 32'd1);
    tick(); chk("t1_busy_c4", {31'd0, busy}, 32'd1);
    tick(); chk("t1_busy_c5", {31'd0, busy}, 32'd0);

    // Two tiles, 3-cycle throughput
    s = cyc;
    push_shift(s + 2, 8'd4, 8'd6, 1'b0);
    push_shift(s + 3, 8'd3, 8'd5, 1'b1);
    push_shift(s + 5, 8'd8, 8'd10, 1'b0);
    push_shift(s + 6, 8'd7, 8'd9, 1'b1);
    push_done(s + 7);
    issue(13'h000F, 4'd2);
    tick(); tick(); tick();
    chk("t2_fetch2_addr", {19'd0, bus.mem_addr}, 32'h13);
    wait_idle("t2");

    // Zero tiles: straight to DONE
    s = cyc;
    push_done(s + 1);
    issue(13'h000F, 4'd0);
    chk("t3_busy_done", {31'd0, busy}, 32'd1);
    wait_idle("t3");

    // Stall 3 cycles in SHIFT_LO; memory scribbled after fetch must not matter
    bus.array_ready = 1'b0;
    s = cyc;
    push_shift(s + 5, 8'd4, 8'd6, 1'b0);
    push_shift(s + 6, 8'd3, 8'd5, 1'b1);
    push_done(s + 7);
    issue(13'h000F, 4'd1);
    tick();
    mem[13'h0011] = 8'd99;
    for (int k = 0; k < 3; k++) begin
      chk("t4_stall_hold", {15'd0, bus.w_shift, bus.w_col0, bus.w_col1}, {15'd0, 1'b0, 8'd4, 8'd6});
      if (k < 2) tick();
    end
    tick();
    bus.array_ready = 1'b1;
    wait_idle("t4");
    mem[13'h0011] = 8'd4;

    // Reset during SHIFT_HI aborts without done/tile_loaded
    s = cyc;
    push_shift(s + 2, 8'd4, 8'd6, 1'b0);
    issue(13'h000F, 4'd1);
    tick(); tick();
    bus.array_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_abort_busy", {31'd0, busy}, 32'd0);
    chk("t5_abort_addr", {19'd0, bus.mem_addr}, 32'd0);
    bus.array_ready = 1'b1;
    tick(); tick(); tick();
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    s = cyc;
    push_shift(s + 2, 8'd8, 8'd10, 1'b0);
    push_shift(s + 3, 8'd7, 8'd9, 1'b1);
    push_done(s + 4);
    issue(13'h0013, 4'd1);
    wait_idle("t5");

    // Address wrap, start pulses while busy ignored
    s = cyc;
    push_shift(s + 2, 8'h33, 8'h44, 1'b0);
    push_shift(s + 3, 8'h11, 8'h22, 1'b1);
    push_shift(s + 5, 8'h77, 8'h88, 1'b0);
    push_shift(s + 6, 8'h55, 8'h66, 1'b1);
    push_done(s + 7);
    issue(13'h1FFE, 4'd2);
    tick();
    base_addr = 13'h0100; num_tiles = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_wrap_addr", {19'd0, bus.mem_addr}, 32'h0002);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("t6");
    tick(); tick(); tick();
    chk("t6_idle_after", {31'd0, busy}, 32'd0);
    chk("queue_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
